// File: rtl/sram_write_buffer.sv
// Posted-write buffer between the CPU bus and the SRAM controller.
// Writes are queued and drained in order; reads wait for the queue to drain.
module sram_write_buffer #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] bus_addr,
  input  logic [31:0] bus_wrdata,
  input  logic [3:0]  bus_bytesel,
  input  logic        bus_wren,
  input  logic        bus_strobe,
  output logic        bus_wait,
  output logic [31:0] bus_rddata,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wrdata,
  output logic [3:0]  mem_bytesel,
  output logic        mem_wren,
  output logic        mem_strobe,
  input  logic        mem_wait,
  input  logic [31:0] mem_rddata,
  output logic        wb_empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state;

  logic [16:0] fifo_addr [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [3:0]  fifo_bsel [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, nx_ptr, src_idx;
  logic [DEPTH_LOG2:0]   count;
  logic full, push, pop, rd_req, rd_done, use_fifo, ld_wr;
  logic [16:0] ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  ld_bsel;

  assign full     = (count == FULL_CNT);
  assign push     = bus_strobe & bus_wren & ~full;
  assign rd_req   = bus_strobe & ~bus_wren;
  assign pop      = (state == WRITE) & ~mem_wait;
  assign rd_done  = (state == READ) & ~mem_wait & rd_req;
  assign nx_ptr   = rd_ptr + 1'b1;

  assign bus_wait   = bus_strobe & (bus_wren ? full : ~rd_done);
  assign bus_rddata = rd_done ? mem_rddata : 32'h0;
  assign wb_empty   = (count == '0) && (state != WRITE);

  // The head entry stays counted until the SRAM accepts it, so the next
  // write to issue is the head (from IDLE) or the entry behind it (from
  // WRITE); when that slot is only being filled this cycle, take the bus.
  always_comb begin
    src_idx  = (state == WRITE) ? nx_ptr : rd_ptr;
    use_fifo = (state == WRITE) ? (|count[DEPTH_LOG2:1]) : (|count);
    ld_wr    = use_fifo | push;
    ld_addr  = use_fifo ? fifo_addr[src_idx] : bus_addr;
    ld_data  = use_fifo ? fifo_data[src_idx] : bus_wrdata;
    ld_bsel  = use_fifo ? fifo_bsel[src_idx] : bus_bytesel;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus_addr;
      fifo_data[wr_ptr] <= bus_wrdata;
      fifo_bsel[wr_ptr] <= bus_bytesel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mem_strobe  <= 1'b0;
      mem_wren    <= 1'b0;
      mem_addr    <= '0;
      mem_wrdata  <= '0;
      mem_bytesel <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= nx_ptr;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (ld_wr) begin
            mem_addr    <= ld_addr;
            mem_wrdata  <= ld_data;
            mem_bytesel <= ld_bsel;
            mem_wren    <= 1'b1;
            mem_strobe  <= 1'b1;
            state       <= WRITE;
          end else if (rd_req) begin
            mem_addr    <= bus_addr;
            mem_wren    <= 1'b0;
            mem_bytesel <= 4'hF;
            mem_strobe  <= 1'b1;
            state       <= READ;
          end
        end
        WRITE: begin
          if (!mem_wait) begin
            if (ld_wr) begin
              mem_addr    <= ld_addr;
              mem_wrdata  <= ld_data;
              mem_bytesel <= ld_bsel;
            end else begin
              mem_strobe <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        READ: begin
          if (!mem_wait) begin
            mem_strobe <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_write_buffer.sv
// Bench for sram_write_buffer: directed vector table, a program-order
// memory model with a simple SRAM responder, and a reset-abort sequence.
module tb_sram_write_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] bus_addr;
  logic [31:0] bus_wrdata;
  logic [3:0]  bus_bytesel;
  logic        bus_wren, bus_strobe, bus_wait;
  logic [31:0] bus_rddata;
  logic [16:0] mem_addr;
  logic [31:0] mem_wrdata;
  logic [3:0]  mem_bytesel;
  logic        mem_wren, mem_strobe, mem_wait;
  logic [31:0] mem_rddata;
  logic        wb_empty;

  int n_chk = 0, n_pass = 0;
  int wr_stalls;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  sram_write_buffer #(.DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset),
    .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_bytesel(bus_bytesel),
    .bus_wren(bus_wren), .bus_strobe(bus_strobe), .bus_wait(bus_wait),
    .bus_rddata(bus_rddata),
    .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_bytesel(mem_bytesel),
    .mem_wren(mem_wren), .mem_strobe(mem_strobe), .mem_wait(mem_wait),
    .mem_rddata(mem_rddata), .wb_empty(wb_empty)
  );

  typedef struct {
    logic        strobe, wren;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bsel;
    logic        mwait;
    logic [31:0] mrd;
    logic        e_wait;
    logic [31:0] e_rd;
    logic        e_mstb, e_mwren;
    logic [16:0] e_maddr;
    logic [31:0] e_mwd;
    logic [3:0]  e_mbsel;
    logic        e_empty;
  } vec_t;

  typedef struct {
    logic        wren;
    logic [16:0] addr;
    logic [31:0] data;
    logic [3:0]  bsel;
  } op_t;

  vec_t tv [13];
  op_t  ops [$];
  logic [31:0] ref_mem [16];
  logic [31:0] sram    [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic drive(input logic s, input logic w, input logic [16:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic mw);
    bus_strobe = s; bus_wren = w; bus_addr = a; bus_wrdata = d; bus_bytesel = be;
    mem_wait = mw;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Plays the CPU (ops queue, held until accepted) and the SRAM (memory array,
  // mem_wait policy by mode) while checking against program-order semantics.
  task automatic run_model(input int mode, input int hold, input bit gaps, input int budget);
    op_t cur, e;
    bit cur_v, done_wr;
    logic rd_done, hold_prev;
    logic [53:0] prev_f;
    op_t exp_wr [$];
    int outstanding, cyc, wcnt;
    cur = '{1'b0, 17'h0, 32'h0, 4'h0};
    cur_v = 0; hold_prev = 0; prev_f = '0;
    outstanding = 0; cyc = 0; wcnt = 0; wr_stalls = 0;
    while ((cur_v || ops.size() > 0 || outstanding > 0) && cyc < budget) begin
      if (!cur_v && ops.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        cur = ops.pop_front();
        cur_v = 1;
      end
      drive(cur_v, cur_v & cur.wren, cur.addr, cur.data, cur.bsel, 1'b0);
      case (mode)
        0:       mem_wait = 1'($urandom_range(0, 1));
        1:       mem_wait = (cyc < hold);
        2:       mem_wait = cyc[0];
        default: mem_wait = mem_strobe && (wcnt < 3);
      endcase
      mem_rddata = (mem_strobe && !mem_wren) ? sram[mem_addr[3:0]] : $urandom;
      @(negedge clk);
      chk("wb_empty", 64'(wb_empty), 64'(outstanding == 0));
      if (hold_prev)
        chk("hold_stable", 64'({mem_strobe, mem_wren, mem_addr, mem_wrdata, mem_bytesel}),
            64'({1'b1, prev_f}));
      if (cur_v && cur.wren) begin
        chk("wr_wait", 64'(bus_wait), 64'(outstanding == DEPTH));
        if (bus_wait) wr_stalls++;
      end
      rd_done = 1'b0;
      if (cur_v && !cur.wren && !bus_wait) begin
        rd_done = 1'b1;
        chk("rd_order", 64'(outstanding), 64'd0);
        chk("rd_mem_done", 64'({mem_strobe, mem_wren, mem_wait}), 64'(3'b100));
        chk("rd_data", 64'(bus_rddata), 64'(ref_mem[cur.addr[3:0]]));
        last_rd = bus_rddata;
      end else begin
        chk("rd_idle_zero", 64'(bus_rddata), 64'd0);
      end
      done_wr = 0;
      if (mem_strobe && !mem_wait) begin
        if (mem_wren) begin
          chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
          if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            chk("wr_txn", 64'({mem_addr, mem_wrdata, mem_bytesel}), 64'({e.addr, e.data, e.bsel}));
            sram[mem_addr[3:0]] = merge(sram[mem_addr[3:0]], mem_wrdata, mem_bytesel);
            done_wr = 1;
          end
        end else begin
          chk("rd_txn", 64'({rd_done, mem_bytesel, mem_addr}), 64'({1'b1, 4'hF, cur.addr}));
        end
      end
      wcnt = (mem_strobe && mem_wait) ? wcnt + 1 : 0;
      hold_prev = mem_strobe && mem_wait;
      prev_f = {mem_wren, mem_addr, mem_wrdata, mem_bytesel};
      if (cur_v && !bus_wait) begin
        if (cur.wren) begin
          ref_mem[cur.addr[3:0]] = merge(ref_mem[cur.addr[3:0]], cur.data, cur.bsel);
          exp_wr.push_back(cur);
          outstanding++;
        end
        cur_v = 0;
      end
      if (done_wr) outstanding--;
      cyc++;
      tick();
    end
    chk("drain_in_budget", 64'(cyc < budget), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 17'h0, 32'h0, 4'h0, 1'b0);
    mem_rddata = 32'h0;
    last_rd = 32'h0;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = 32'h0; sram[i] = 32'h0; end

    tv[0]  = '{1,1,17'h10,32'hDEADBEEF,4'hF, 0,32'h0,        0,32'h0,        0,0,17'h0, 32'h0,        4'h0,1};
    tv[1]  = '{0,0,17'h0, 32'h0,       4'h0, 0,32'h0,        0,32'h0,        1,1,17'h10,32'hDEADBEEF,4'hF,0};
    tv[2]  = '{0,0,17'h0, 32'h0,       4'h0, 0,32'h0,        0,32'h0,        0,1,17'h10,32'hDEADBEEF,4'hF,1};
    tv[3]  = '{1,0,17'h55,32'h0,       4'h0, 0,32'hCAFEF00D, 1,32'h0,        0,1,17'h10,32'hDEADBEEF,4'hF,1};
    tv[4]  = '{1,0,17'h55,32'h0,       4'h0, 0,32'hCAFEF00D, 0,32'hCAFEF00D, 1,0,17'h55,32'hDEADBEEF,4'hF,1};
    tv[5]  = '{0,0,17'h0, 32'h0,       4'h0, 0,32'h0,        0,32'h0,        0,0,17'h55,32'hDEADBEEF,4'hF,1};
    tv[6]  = '{1,0,17'h77,32'h0,       4'h0, 1,32'h11223344, 1,32'h0,        0,0,17'h55,32'hDEADBEEF,4'hF,1};
    tv[7]  = '{1,0,17'h77,32'h0,       4'h0, 1,32'h11223344, 1,32'h0,        1,0,17'h77,32'hDEADBEEF,4'hF,1};
    tv[8]  = '{1,0,17'h77,32'h0,       4'h0, 0,32'h11223344, 0,32'h11223344, 1,0,17'h77,32'hDEADBEEF,4'hF,1};
    tv[9]  = '{1,1,17'h3, 32'hA5A5A5A5,4'h3, 1,32'h0,        0,32'h0,        0,0,17'h77,32'hDEADBEEF,4'hF,1};
    tv[10] = '{0,0,17'h0, 32'h0,       4'h0, 1,32'h0,        0,32'h0,        1,1,17'h3, 32'hA5A5A5A5,4'h3,0};
    tv[11] = '{0,0,17'h0, 32'h0,       4'h0, 0,32'h0,        0,32'h0,        1,1,17'h3, 32'hA5A5A5A5,4'h3,0};
    tv[12] = '{0,0,17'h0, 32'h0,       4'h0, 0,32'h0,        0,32'h0,        0,1,17'h3, 32'hA5A5A5A5,4'h3,1};

    tick();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(tv[i].strobe, tv[i].wren, tv[i].addr, tv[i].wdata, tv[i].bsel, tv[i].mwait);
      mem_rddata = tv[i].mrd;
      @(negedge clk);
      chk($sformatf("tv%0d.bus_wait", i),    64'(bus_wait),    64'(tv[i].e_wait));
      chk($sformatf("tv%0d.bus_rddata", i),  64'(bus_rddata),  64'(tv[i].e_rd));
      chk($sformatf("tv%0d.mem_strobe", i),  64'(mem_strobe),  64'(tv[i].e_mstb));
      chk($sformatf("tv%0d.mem_wren", i),    64'(mem_wren),    64'(tv[i].e_mwren));
      chk($sformatf("tv%0d.mem_addr", i),    64'(mem_addr),    64'(tv[i].e_maddr));
      chk($sformatf("tv%0d.mem_wrdata", i),  64'(mem_wrdata),  64'(tv[i].e_mwd));
      chk($sformatf("tv%0d.mem_bytesel", i), 64'(mem_bytesel), 64'(tv[i].e_mbsel));
      chk($sformatf("tv%0d.wb_empty", i),    64'(wb_empty),    64'(tv[i].e_empty));
      tick();
    end

    // Five writes against a stalled SRAM: the fifth waits through the release cycle.
    for (int i = 0; i < 5; i++)
      ops.push_back('{1'b1, 17'h100 + 17'(i), 32'hA0000000 + 32'(i), 4'hF});
    run_model(1, 8, 0, 100);
    chk("full_stall_cycles", 64'(wr_stalls), 64'd5);

    // Write then read of the same word, three wait cycles per SRAM access.
    last_rd = 32'h0;
    ops.push_back('{1'b1, 17'h20, 32'h12345678, 4'hF});
    ops.push_back('{1'b0, 17'h20, 32'h0, 4'h0});
    run_model(3, 0, 0, 100);
    chk("raw_read_data", 64'(last_rd), 64'h12345678);

    // Pointer wrap with alternating mem_wait.
    for (int i = 0; i < 10; i++)
      ops.push_back('{1'b1, 17'(i), $urandom, 4'hF});
    run_model(2, 0, 0, 200);

    for (int i = 0; i < 300; i++)
      ops.push_back('{($urandom_range(0, 9) < 7), 17'($urandom_range(0, 15)), $urandom,
                      4'($urandom_range(0, 15))});
    run_model(0, 0, 1, 6000);

    // Reset with three writes held in the buffer and one in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 17'(i + 1), 32'h5000 + 32'(i), 4'hF, 1'b1);
      @(negedge clk);
      chk($sformatf("pre_reset_accept%0d", i), 64'(bus_wait), 64'd0);
      tick();
    end
    drive(1'b0, 1'b0, 17'h0, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    chk("pre_reset_strobe", 64'(mem_strobe), 64'd1);
    chk("pre_reset_empty", 64'(wb_empty), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_wait = 1'b0;
    @(negedge clk);
    chk("post_reset_strobe", 64'(mem_strobe), 64'd0);
    chk("post_reset_empty", 64'(wb_empty), 64'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset_quiet%0d", i), 64'({mem_strobe, wb_empty}), 64'(2'b01));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
